// File: rtl/panel_script_sequencer.sv
// Front-panel script player: replays switch-register loads and key pulses, then monitors the CPU for pass/halt/timeout.
// PDP-8 bit 0 is the MSB: prog_data[14:12] is the opcode, prog_data[11:0] the SR value; address/sr_out likewise MSB-first.
module panel_script_sequencer #(
  parameter int NUM_STEPS     = 8,
  parameter int SETUP_CYCLES  = 4,
  parameter int PULSE_CYCLES  = 12,
  parameter int GAP_CYCLES    = 6000,
  parameter int TIMEOUT_W     = 32,
  parameter int AUTO_CONT_MAX = 0,
  localparam int AW = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [14:0]          prog_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic [14:0]          pass_addr,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [14:0]          address,
  input  logic                 halted,
  output logic [11:0]          sr_out,
  output logic                 addr_load,
  output logic                 dep,
  output logic                 exam,
  output logic                 cont,
  output logic                 clear,
  output logic                 extd_addr,
  output logic                 busy,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [AW-1:0]        step_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_MON, S_ACP, S_ACG, S_PASS, S_FAIL
  } state_t;

  localparam logic [AW-1:0] IDX0    = '0;
  localparam logic [AW-1:0] IDX_END = AW'(NUM_STEPS - 1);
  localparam logic [5:0]    KEY_CONT = 6'b001000;

  state_t                 state_q;
  logic [14:0]            tbl_q [NUM_STEPS];
  logic [15:0]            ctr_q;
  logic [TIMEOUT_W-1:0]   mon_cnt_q;
  logic [7:0]             acont_q;
  logic [AW-1:0]          idx_q;
  logic [11:0]            sr_q;
  logic [5:0]             key_q;
  logic                   pass_q;
  logic [1:0]             fail_q;
  logic [2:0]             cur_op_d;
  logic [AW-1:0]          next_idx_d;

  assign busy = !(state_q == S_IDLE || state_q == S_PASS || state_q == S_FAIL);
  assign cur_op_d   = tbl_q[idx_q][14:12];
  assign next_idx_d = idx_q + 1'b1;

  // Table is deliberately not reset so a script survives a reset and can be re-run.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) tbl_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      mon_cnt_q <= '0;
      acont_q   <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      key_q     <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 2'd0;
    end else if (busy && abort) begin
      state_q <= S_FAIL;
      fail_q  <= 2'd3;
      key_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            idx_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 2'd0;
            acont_q <= '0;
            ctr_q   <= '0;
            sr_q    <= tbl_q[IDX0][11:0];
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cur_op_d == 3'd0) begin
            mon_cnt_q <= '0;
            state_q   <= S_MON;
          end else if (ctr_q == 16'(SETUP_CYCLES - 1)) begin
            ctr_q <= '0;
            if (cur_op_d == 3'd7) begin
              state_q <= S_GAP;
            end else begin
              key_q   <= 6'b000001 << (cur_op_d - 3'd1);
              state_q <= S_PULSE;
            end
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_PULSE, S_ACP: begin
          if (ctr_q == 16'(PULSE_CYCLES - 1)) begin
            key_q   <= '0;
            ctr_q   <= '0;
            state_q <= (state_q == S_ACP) ? S_ACG : S_GAP;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_GAP: begin
          if (ctr_q == 16'(GAP_CYCLES - 1)) begin
            ctr_q <= '0;
            // Finishing the last table entry ends the script rather than wrapping.
            if (idx_q == IDX_END) begin
              mon_cnt_q <= '0;
              state_q   <= S_MON;
            end else begin
              idx_q   <= next_idx_d;
              sr_q    <= tbl_q[next_idx_d][11:0];
              state_q <= S_SETUP;
            end
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_ACG: begin
          if (ctr_q == 16'(GAP_CYCLES - 1)) begin
            ctr_q   <= '0;
            state_q <= S_MON;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_MON: begin
          mon_cnt_q <= mon_cnt_q + 1'b1;
          if (address == pass_addr) begin
            pass_q  <= 1'b1;
            state_q <= S_PASS;
          end else if (halted) begin
            if (32'(acont_q) < AUTO_CONT_MAX) begin
              acont_q <= acont_q + 1'b1;
              key_q   <= KEY_CONT;
              ctr_q   <= '0;
              state_q <= S_ACP;
            end else begin
              fail_q  <= 2'd1;
              state_q <= S_FAIL;
            end
          end else if (timeout != '0 && mon_cnt_q == timeout - 1'b1) begin
            fail_q  <= 2'd2;
            state_q <= S_FAIL;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {extd_addr, clear, cont, exam, dep, addr_load} = key_q;
  assign sr_out    = sr_q;
  assign pass      = pass_q;
  assign fail_code = fail_q;
  assign step_idx  = idx_q;

endmodule

// File: tb/tb_panel_script_sequencer.sv
// Scoreboard bench for panel_script_sequencer: a script-level timing model predicts key pulses and the final verdict.
module tb_panel_script_sequencer;
  localparam int NS = 8, SU = 4, PW = 12, GP = 40, ACM = 2;
  localparam int BIG = 32'h3fffffff;

  logic clk = 1'b0, reset = 1'b1, prog_we = 1'b0, start = 1'b0, abort = 1'b0, halted = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [14:0] prog_data = '0, pass_addr = '0, address = '0;
  logic [31:0] timeout = '0;
  logic [11:0] sr_out;
  logic addr_load, dep, exam, cont, clear, extd_addr, busy, pass;
  logic [1:0] fail_code;
  logic [2:0] step_idx;
  logic [5:0] key_vec;

  panel_script_sequencer #(.NUM_STEPS(NS), .SETUP_CYCLES(SU), .PULSE_CYCLES(PW),
    .GAP_CYCLES(GP), .TIMEOUT_W(32), .AUTO_CONT_MAX(ACM)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .abort(abort), .pass_addr(pass_addr), .timeout(timeout), .address(address),
    .halted(halted), .sr_out(sr_out), .addr_load(addr_load), .dep(dep), .exam(exam), .cont(cont),
    .clear(clear), .extd_addr(extd_addr), .busy(busy), .pass(pass), .fail_code(fail_code),
    .step_idx(step_idx));

  assign key_vec = {extd_addr, clear, cont, exam, dep, addr_load};
  always #5 clk = ~clk;

  typedef struct {
    bit is_end; logic [5:0] key; logic [11:0] sr; int w; int cyc; logic ps; logic [1:0] fc;
  } ev_t;

  ev_t exp_q[$];
  logic [14:0] scr [NS];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_pulse(logic [5:0] k, logic [11:0] sr, int c);
    ev_t e;
    e.is_end = 1'b0; e.key = k; e.sr = sr; e.w = PW; e.cyc = c; e.ps = 1'b0; e.fc = 2'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_end(logic ps, logic [1:0] fc, int c);
    ev_t e;
    e.is_end = 1'b1; e.key = '0; e.sr = '0; e.w = 0; e.cyc = c; e.ps = ps; e.fc = fc;
    exp_q.push_back(e);
  endfunction

  // Walk the script: each keyed step costs setup+pulse+gap, SR-only costs setup+gap, END costs one cycle.
  function automatic void model(input int s, input int cut, output int mon, output logic [11:0] lsr);
    int t;
    bit done;
    logic [2:0] op;
    t = s + 1; done = 1'b0; mon = 0; lsr = '0;
    for (int k = 0; k < NS; k++) begin
      if (!done) begin
        op = scr[k][14:12];
        lsr = scr[k][11:0];
        if (op == 3'd0) begin
          mon = t + 1; done = 1'b1;
        end else if (op == 3'd7) begin
          t += SU + GP;
        end else begin
          if (t + SU < cut) push_pulse(6'b000001 << (op - 3'd1), scr[k][11:0], t + SU);
          t += SU + PW + GP;
        end
      end
    end
    if (!done) mon = t;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: reconstructs key pulses and verdicts from the pins and pops the scoreboard.
  bit in_p = 1'b0, prev_busy = 1'b0;
  logic [5:0] p_key;
  logic [11:0] p_sr;
  int p_w, p_cyc;

  task automatic mon_pulse();
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL pulse: unexpected key=%b sr=%o w=%0d cyc=%0d", p_key, p_sr, p_w, p_cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_end || e.key != p_key || e.sr != p_sr || e.w != p_w || e.cyc != p_cyc) begin
        n_bad++;
        $display("FAIL pulse: got key=%b sr=%o w=%0d cyc=%0d want end=%0b key=%b sr=%o w=%0d cyc=%0d",
                 p_key, p_sr, p_w, p_cyc, e.is_end, e.key, e.sr, e.w, e.cyc);
      end
    end
  endtask

  task automatic mon_end();
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL verdict: unexpected pass=%0b fail_code=%0d cyc=%0d", pass, fail_code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (!e.is_end || e.ps != pass || e.fc != fail_code || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL verdict: got pass=%0b fail_code=%0d cyc=%0d want end=%0b pass=%0b fail_code=%0d cyc=%0d",
                 pass, fail_code, cyc, e.is_end, e.ps, e.fc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_p = 1'b0; prev_busy = 1'b0;
    end else begin
      if (in_p) begin
        if (key_vec == p_key) p_w++;
        else begin mon_pulse(); in_p = 1'b0; end
      end
      if (!in_p && key_vec != '0) begin
        in_p = 1'b1; p_key = key_vec; p_sr = sr_out; p_cyc = cyc; p_w = 1;
      end
      if (prev_busy && !busy) mon_end();
      prev_busy = busy;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic prog_all();
    for (int k = 0; k < NS; k++) begin
      @(negedge clk); prog_we = 1'b1; prog_addr = 3'(k); prog_data = scr[k];
    end
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // mode: 0 pass, 1 timeout, 2 halt, 3 abort at s+cut_rel, 4 abort with pass match, 5 no timeout then abort
  task automatic run(input int mode, input int tmo, input int cut_rel, input bit bw, input bit idxchk);
    int s, mon;
    logic [11:0] lsr;
    logic [14:0] pa;
    pa = 15'($urandom);
    pass_addr = pa;
    address = (mode == 0) ? pa : ~pa;
    halted = (mode == 2);
    timeout = 32'(tmo);
    @(negedge clk); start = 1'b1; s = cyc;
    model(s, (mode == 3) ? s + cut_rel : BIG, mon, lsr);
    case (mode)
      0: push_end(1'b1, 2'd0, mon + 1);
      1: push_end(1'b0, 2'd2, mon + tmo);
      2: begin
        for (int k = 0; k < ACM; k++) push_pulse(6'b001000, lsr, mon + 1 + k * (1 + PW + GP));
        push_end(1'b0, 2'd1, mon + ACM * (1 + PW + GP) + 1);
      end
      3: push_end(1'b0, 2'd3, s + cut_rel + 1);
      4: push_end(1'b0, 2'd3, mon + 1);
      default: ;
    endcase
    @(negedge clk); start = 1'b0;
    if (bw) begin
      prog_we = 1'b1; prog_addr = 3'd1; prog_data = 15'o77777;
      @(negedge clk); prog_we = 1'b0;
    end
    if (idxchk) begin
      for (int k = 0; k < NS; k++) begin
        wait_cyc(s + 2 + k * (SU + GP));
        chk("step_idx", int'(step_idx), k);
      end
      wait_cyc(mon);
      chk("step_idx_at_monitor", int'(step_idx), NS - 1);
      chk("busy_at_monitor", int'(busy), 1);
    end
    if (mode == 3) begin
      wait_cyc(s + cut_rel); abort = 1'b1; @(negedge clk); abort = 1'b0;
    end
    if (mode == 4) begin
      wait_cyc(mon); address = pa; abort = 1'b1; @(negedge clk); abort = 1'b0;
    end
    if (mode == 5) begin
      wait_cyc(mon + 10000);
      chk("no_timeout_busy", int'(busy), 1);
      chk("no_timeout_fail_code", int'(fail_code), 0);
      push_end(1'b0, 2'd3, cyc + 1);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
    end
    drain();
    halted = 1'b0;
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_keys", int'(key_vec), 0);
    chk("reset_sr_out", int'(sr_out), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_fail_code", int'(fail_code), 0);
    chk("reset_step_idx", int'(step_idx), 0);
    #2 reset = 1'b0;

    scr = '{15'o10200, 15'o40200, 15'o00200, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all(); run(0, 0, BIG, 1'b0, 1'b0);
    chk("pass_sticky", int'(pass), 1);

    scr = '{15'o10020, 15'o20002, 15'o20304, 15'o21200, 15'o00000, 15'o0, 15'o0, 15'o0};
    prog_all(); run(0, 0, BIG, 1'b0, 1'b0);

    scr = '{15'o10020, 15'o20002, 15'o00000, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all(); run(0, 0, BIG, 1'b1, 1'b0);
    run(3, 0, 5 + PW + 10, 1'b0, 1'b0);

    scr = '{15'o30123, 15'o00000, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all(); run(1, 100, BIG, 1'b0, 1'b0);

    scr = '{15'o50055, 15'o00000, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all(); run(2, 0, BIG, 1'b0, 1'b0);
    run(2, 0, BIG, 1'b0, 1'b0);

    for (int k = 0; k < NS; k++) scr[k] = {3'd7, 12'($urandom)};
    prog_all(); run(0, 0, BIG, 1'b0, 1'b1);

    scr = '{15'o00000, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all(); run(4, 0, BIG, 1'b0, 1'b0);
    run(5, 0, BIG, 1'b0, 1'b0);

    // Reset in the middle of a pulse, then replay the retained table.
    scr = '{15'o10777, 15'o00000, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0, 15'o0};
    prog_all();
    @(negedge clk); start = 1'b1; s = cyc;
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 1 + SU + 5);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_pulse_key", int'(addr_load), 0);
    chk("reset_mid_pulse_busy", int'(busy), 0);
    @(negedge clk); #2 reset = 1'b0;
    run(0, 0, BIG, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NS; k++) scr[k] = {3'($urandom_range(0, 7)), 12'($urandom)};
      prog_all();
      run($urandom_range(0, 2), $urandom_range(20, 170), BIG, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
